fifo_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream fifo_af enqueue port between NUM_REQ valid/ready producer streams.
- Grants are burst-locked: a winner keeps the output until it sends in_last or MAX_BURST beats have fired.
- New bursts start only while the downstream FIFO's almost_full is low.
- Sits between the producer engines and the shared command/data FIFO; out_src tags each beat with its origin.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/fifo_rr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_rr_arbiter.sv | 95 +++++++++
 tb/tb_fifo_rr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO round-robin arbiter: state encoding and
// a constant clog2 used to size the requester index and the beat counter.
package fifo_arb_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_BURST = 1'b1;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_BURST = ST_BURST
   } arb_state_e;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request after
// position 'last', wrapping modulo NUM_REQ, using a doubled request vector.
import fifo_arb_pkg::*;

module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     last,
   output logic               any,
   output logic [IDW-1:0]     idx
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [IDW:0]         sh;

   // Rotate so bit 0 is the slot after 'last', then take the lowest set bit.
   always_comb begin
      dbl = {req, req};
      sh  = {1'b0, last} + {{IDW{1'b0}}, 1'b1};
      rot = NUM_REQ'(dbl >> sh);
      any = |req;
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) idx = IDW'((int'(last) + 1 + k) % NUM_REQ);
      end
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Burst-locked round-robin arbiter feeding one FIFO enqueue port. A winner
// keeps the port until in_last or MAX_BURST beats; new bursts start only
// while the FIFO is not almost full. One idle cycle separates bursts.
import fifo_arb_pkg::*;

module fifo_rr_arbiter #(
   parameter int  WIDTH     = 32,
   parameter int  NUM_REQ   = 4,
   parameter int  MAX_BURST = 8,
   localparam int IDW       = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1,
   localparam int BW        = clog2(MAX_BURST + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       in_valid,
   input  logic [NUM_REQ*WIDTH-1:0] in_data,
   input  logic [NUM_REQ-1:0]       in_last,
   output logic [NUM_REQ-1:0]       in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_last,
   output logic [IDW-1:0]           out_src,
   input  logic                     out_ready,
   input  logic                     fifo_almost_full,
   output logic                     busy
);

   arb_state_e       state_q;
   logic [IDW-1:0]   grant_q;
   logic [IDW-1:0]   last_grant_q;
   logic [BW-1:0]    beat_q;
   logic             pick_any;
   logic [IDW-1:0]   pick_idx;
   logic             in_burst;
   logic             fire;
   logic [WIDTH-1:0] lane [NUM_REQ];

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .req  (in_valid),
      .last (last_grant_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign in_burst = (state_q == S_BURST);

   // Unpack per-requester lanes and route the downstream ready to the owner only.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane[gi]     = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = in_burst && (grant_q == IDW'(gi)) && out_ready;
   end

   assign out_valid = in_burst && in_valid[grant_q];
   assign out_data  = in_burst ? lane[grant_q] : '0;
   assign out_src   = in_burst ? grant_q : '0;
   assign out_last  = out_valid && (in_last[grant_q] || (beat_q == BW'(MAX_BURST - 1)));
   assign fire      = out_valid && out_ready;
   assign busy      = in_burst;

   // Sequencing: arbitrate in IDLE, stream beats in BURST until the last one fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         beat_q       <= '0;
         last_grant_q <= IDW'(NUM_REQ - 1);
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_any && !fifo_almost_full) begin
                  grant_q <= pick_idx;
                  beat_q  <= '0;
                  state_q <= S_BURST;
               end
            end
            S_BURST: begin
               if (fire) begin
                  if (out_last) begin
                     last_grant_q <= grant_q;
                     beat_q       <= '0;
                     state_q      <= S_IDLE;
                  end else begin
                     beat_q <= beat_q + BW'(1);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: a transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fifo_rr_arbiter;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int MB    = 8;
   localparam int IDW   = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N-1:0]         in_valid;
   logic [N*WIDTH-1:0]   in_data;
   logic [N-1:0]         in_last;
   logic [N-1:0]         in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic                 out_last;
   logic [IDW-1:0]       out_src;
   logic                 out_ready;
   logic                 fifo_almost_full;
   logic                 busy;

   fifo_rr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(N), .MAX_BURST(MB)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_last          (in_last),
      .in_ready         (in_ready),
      .out_valid        (out_valid),
      .out_data         (out_data),
      .out_last         (out_last),
      .out_src          (out_src),
      .out_ready        (out_ready),
      .fifo_almost_full (fifo_almost_full),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Producers: rem beats left, seq beat number, every = in_last on each beat.
   int           rem   [N];
   int           seq   [N];
   bit           every [N];
   bit           hold  [N];
   logic [N-1:0] hs;

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         in_valid[i] = (rem[i] > 0) && !hold[i];
         in_last[i]  = every[i] || (rem[i] == 1);
         in_data[i*WIDTH +: WIDTH] = {i[7:0], seq[i][23:0]};
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            rem[i] = rem[i] - 1;
            seq[i] = seq[i] + 1;
         end
      end
      drive();
   endtask

   // Reference model: who owns the port and how many beats it has sent.
   int m_busy  = 0;
   int m_owner = 0;
   int m_sent  = 0;
   int m_prev  = N - 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  = 0;
         m_owner = 0;
         m_sent  = 0;
         m_prev  = N - 1;
      end else if (m_busy == 0) begin
         if (in_valid != '0 && !fifo_almost_full) begin
            for (int k = N; k >= 1; k--) begin
               if (in_valid[(m_prev + k) % N]) m_owner = (m_prev + k) % N;
            end
            m_sent = 0;
            m_busy = 1;
         end
      end else if (in_valid[m_owner] && out_ready) begin
         m_sent = m_sent + 1;
         if (in_last[m_owner] || m_sent == MB) begin
            m_prev = m_owner;
            m_busy = 0;
         end
      end
   end

   // Fire log taken from the DUT for the literal scenario checks.
   int         f_src  [$];
   bit         f_last [$];
   logic [31:0] f_data [$];
   int         f_cyc  [$];

   logic             e_valid;
   logic             e_last;
   logic [N-1:0]     e_ready;
   logic [WIDTH-1:0] e_data;
   logic [IDW-1:0]   e_src;

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      e_valid = (m_busy != 0) && in_valid[m_owner];
      e_last  = e_valid && (in_last[m_owner] || m_sent == MB - 1);
      e_ready = '0;
      if (m_busy != 0 && out_ready) e_ready[m_owner] = 1'b1;
      e_data  = (m_busy != 0) ? in_data[m_owner*WIDTH +: WIDTH] : '0;
      e_src   = (m_busy != 0) ? IDW'(m_owner) : '0;
      chk("busy", busy, m_busy[0]);
      chk("out_valid", out_valid, e_valid);
      chk("out_last", out_last, e_last);
      chk("in_ready", in_ready, e_ready);
      if (m_busy != 0 || !rst_n) begin
         chk("out_src", out_src, e_src);
         chk("out_data", out_data, e_data);
      end
      hs = in_valid & in_ready;
      if (out_valid && out_ready) begin
         f_src.push_back(int'(out_src));
         f_last.push_back(out_last);
         f_data.push_back(out_data);
         f_cyc.push_back(cyc);
      end
   end

   task automatic clear_log();
      f_src.delete();
      f_last.delete();
      f_data.delete();
      f_cyc.delete();
   endtask

   task automatic wait_fires(input int n, input int bound);
      int b;
      b = 0;
      while (f_src.size() < n && b < bound) begin
         step();
         b++;
      end
      if (f_src.size() < n) begin
         n_total++;
         $display("FAIL fire_timeout: got %0d fires expected %0d", f_src.size(), n);
      end
   endtask

   task automatic wait_busy(input int bound);
      int b;
      b = 0;
      while (!busy && b < bound) begin
         step();
         b++;
      end
      if (!busy) begin
         n_total++;
         $display("FAIL busy_timeout: got busy=0 expected 1");
      end
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; seq[i] = 0; every[i] = 1'b0; hold[i] = 1'b0;
      end
      out_ready = 1'b1;
      fifo_almost_full = 1'b0;
      drive();
      step();
      step();
      rst_n = 1'b1;
      clear_log();
   endtask

   initial begin
      int rot_exp [5];
      rot_exp = '{0, 1, 2, 3, 0};
      rst_n = 1'b0;
      out_ready = 1'b1;
      fifo_almost_full = 1'b0;
      hs = '0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 100; seq[i] = 0; every[i] = 1'b1; hold[i] = 1'b0;
      end
      drive();

      // Reset with every requester valid, then the first grant.
      step();
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      rst_n = 1'b1;
      clear_log();
      #1;
      chk("idle_gap_busy", busy, 0);
      step();
      chk("first_src", out_src, 0);
      chk("first_ready", in_ready, 4'b0001);
      chk("first_busy", busy, 1);

      // Rotation with in_last on every beat: one beat every two cycles.
      wait_fires(5, 40);
      for (int k = 0; k < 5; k++)
         if (k < f_src.size()) chk("rot_src", f_src[k], rot_exp[k]);
      for (int k = 0; k < 4; k++)
         if (k + 1 < f_cyc.size()) chk("rot_gap", f_cyc[k+1] - f_cyc[k], 2);

      // Burst cap: requester 2 alone, 20 beats, in_last only on the final one.
      reset_dut();
      rem[2] = 20;
      drive();
      wait_fires(20, 120);
      chk("cap_count", f_src.size(), 20);
      for (int k = 0; k < 20; k++)
         if (k < f_last.size()) chk("cap_last", f_last[k], (k == 7 || k == 15 || k == 19));
      if (f_src.size() >= 20) begin
         chk("cap_src", f_src[16], 2);
         chk("cap_data", f_data[19], 32'h0200_0013);
      end

      // Almost full: blocks arbitration, not an active burst.
      reset_dut();
      fifo_almost_full = 1'b1;
      rem[1] = 5;
      drive();
      repeat (5) step();
      chk("af_idle_busy", busy, 0);
      chk("af_idle_valid", out_valid, 0);
      fifo_almost_full = 1'b0;
      wait_fires(2, 20);
      fifo_almost_full = 1'b1;
      rem[3] = 2;
      drive();
      wait_fires(5, 20);
      if (f_last.size() >= 5) chk("af_burst_last", f_last[4], 1);
      repeat (4) step();
      chk("af_hold_busy", busy, 0);
      chk("af_hold_valid", out_valid, 0);
      chk("af_hold_fires", f_src.size(), 5);
      fifo_almost_full = 1'b0;
      wait_busy(10);
      chk("af_next_src", out_src, 3);

      // Stall and lock.
      reset_dut();
      rem[0] = 6;
      rem[2] = 3;
      drive();
      wait_fires(2, 20);
      out_ready = 1'b0;
      repeat (5) begin
         step();
         chk("stall_data", out_data, 32'h0000_0002);
         chk("stall_valid", out_valid, 1);
      end
      chk("stall_fires", f_src.size(), 2);
      out_ready = 1'b1;
      hold[0] = 1'b1;
      drive();
      repeat (3) begin
         step();
         chk("lock_busy", busy, 1);
         chk("lock_src", out_src, 0);
         chk("lock_ready", in_ready, 4'b0001);
         chk("lock_valid", out_valid, 0);
      end
      hold[0] = 1'b0;
      drive();
      wait_fires(9, 60);
      for (int k = 0; k < 9; k++)
         if (k < f_src.size()) chk("lock_seq", f_src[k], (k < 6) ? 0 : 2);
      if (f_last.size() >= 6) chk("lock_last", f_last[5], 1);

      // Asynchronous reset in the middle of requester 1's burst.
      reset_dut();
      rem[1] = 5;
      rem[2] = 5;
      drive();
      wait_fires(2, 20);
      if (f_src.size() >= 1) chk("ar_owner", f_src[0], 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_ready", in_ready, 0);
      chk("ar_last", out_last, 0);
      rem[0] = 3;
      drive();
      step();
      rst_n = 1'b1;
      wait_busy(10);
      chk("ar_next_src", out_src, 0);

      repeat (2) step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
